// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit with architectural HI/LO.
// mult/multu/madd take MUL_LAT busy cycles. div/divu use restoring radix-2
// division on magnitudes and take DATA_W busy cycles. mthi/mtlo write in a
// single cycle. Define MULDIV_MADD_EN to build the signed multiply-accumulate
// (op 7). Without it, op 7 behaves like op 0.
module ex_muldiv #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [2:0]        md_op_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              div_by_zero_o,
   output logic              stallsignal
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MULDIV_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'd7;
`endif

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                dbz_q, dbz_d;
   logic [2:0]          op_q, op_d;
   logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
   logic                negq_q, negq_d, negr_q, negr_d;

   logic                is_mul_op, is_div_op, div_signed;
   logic signed [2*DATA_W-1:0] prod_s;
   logic [2*DATA_W-1:0] prod_u, mul_res;
   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   rem_nx, quo_nx;

   // Absolute value of a two's-complement operand when treated as signed;
   // MIN maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
      return (is_signed && v[DATA_W-1]) ? -v : v;
   endfunction

   // Restores the sign of a quotient or remainder after magnitude division.
   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                    input logic neg);
      return neg ? -v : v;
   endfunction

   // Classify the presented op; madd only counts as a multiply when built in.
   always_comb begin
      div_signed = (md_op_i == OP_DIV);
      is_div_op  = (md_op_i == OP_DIV) || (md_op_i == OP_DIVU);
`ifdef MULDIV_MADD_EN
      is_mul_op  = (md_op_i == OP_MULT) || (md_op_i == OP_MULTU) || (md_op_i == OP_MADD);
`else
      is_mul_op  = (md_op_i == OP_MULT) || (md_op_i == OP_MULTU);
`endif
   end

   // Full-width product of the latched operands, selected by the latched op.
   always_comb begin
      prod_s  = $signed({{DATA_W{opa_q[DATA_W-1]}}, opa_q}) *
                $signed({{DATA_W{opb_q[DATA_W-1]}}, opb_q});
      prod_u  = {{DATA_W{1'b0}}, opa_q} * {{DATA_W{1'b0}}, opb_q};
      mul_res = prod_u;
      if (op_q == OP_MULT)
         mul_res = prod_s;
`ifdef MULDIV_MADD_EN
      else if (op_q == OP_MADD)
         mul_res = {hi_q, lo_q} + prod_s;
`endif
   end

   // One restoring-division step: shift in the next dividend bit, try to subtract.
   always_comb begin
      trial = {rem_q, opa_q[DATA_W-1]} - {1'b0, opb_q};
      if (trial[DATA_W]) begin
         rem_nx = {rem_q[DATA_W-2:0], opa_q[DATA_W-1]};
         quo_nx = {opa_q[DATA_W-2:0], 1'b0};
      end else begin
         rem_nx = trial[DATA_W-1:0];
         quo_nx = {opa_q[DATA_W-2:0], 1'b1};
      end
   end

   // Sequencer: accept, iterate, commit HI/LO, and handle flush.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               if (is_mul_op) begin
                  state_d = S_MUL;
                  cnt_d   = CNT_W'(MUL_LAT);
                  op_d    = md_op_i;
                  opa_d   = reg1_i;
                  opb_d   = reg2_i;
               end else if (is_div_op) begin
                  if (reg2_i == '0) begin
                     state_d = S_DONE;
                     dbz_d   = 1'b1;
                  end else begin
                     state_d = S_DIV;
                     cnt_d   = CNT_W'(DATA_W);
                     op_d    = md_op_i;
                     opa_d   = magnitude(reg1_i, div_signed);
                     opb_d   = magnitude(reg2_i, div_signed);
                     rem_d   = '0;
                     negq_d  = div_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                     negr_d  = div_signed && reg1_i[DATA_W-1];
                  end
               end else if (md_op_i == OP_MTHI) begin
                  hi_d = reg1_i;
               end else if (md_op_i == OP_MTLO) begin
                  lo_d = reg1_i;
               end
            end
         end
         S_MUL: begin
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  {hi_d, lo_d} = mul_res;
                  state_d      = S_DONE;
               end
            end
         end
         S_DIV: begin
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               opa_d = quo_nx;
               rem_d = rem_nx;
               if (cnt_q == CNT_W'(1)) begin
                  lo_d    = apply_sign(quo_nx, negq_q);
                  hi_d    = apply_sign(rem_nx, negr_q);
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            // DONE: the still-presented instruction is ignored; results are committed.
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and architectural HI/LO registers, synchronously reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   // Operand and iteration datapath registers; only meaningful while busy.
   always_ff @(posedge clk) begin
      op_q   <= op_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      rem_q  <= rem_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
   end

   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign busy_o        = (state_q == S_MUL) || (state_q == S_DIV);
   assign done_o        = (state_q == S_DONE);
   assign div_by_zero_o = dbz_q;
   assign stallsignal   = ((state_q == S_IDLE) && start_i && !flush_i && (is_mul_op || is_div_op))
                          || busy_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (DATA_W=32, MUL_LAT=2): directed cases
// followed by randomized ops, checked against an arithmetic HI/LO model.
module tb_ex_muldiv;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  md_op_i;
   logic [31:0] reg1_i, reg2_i;
   logic        flush_i;
   logic [31:0] hi_o, lo_o;
   logic        busy_o, done_o, div_by_zero_o, stallsignal;

   int n_cmp = 0;
   int n_mis = 0;

   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   ex_muldiv #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .md_op_i(md_op_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
      .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o),
      .div_by_zero_o(div_by_zero_o), .stallsignal(stallsignal)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural effect of one op plus its expected stall length / DONE cycle.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int e_stall, output int e_done, output bit e_dbz);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e_stall = 0;
      e_done  = -1;
      e_dbz   = 1'b0;
      case (op)
         3'd1: begin
            p = sa * sb;
            {m_hi, m_lo} = p;
            e_stall = MUL_LAT + 1;
            e_done  = MUL_LAT + 1;
         end
         3'd2: begin
            p = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = p;
            e_stall = MUL_LAT + 1;
            e_done  = MUL_LAT + 1;
         end
         3'd3, 3'd4: begin
            if (b == 32'd0) begin
               e_dbz   = 1'b1;
               e_stall = 1;
               e_done  = 1;
            end else begin
               if (op == 3'd3) begin
                  m_lo = 32'(sa / sb);
                  m_hi = 32'(sa % sb);
               end else begin
                  m_lo = a / b;
                  m_hi = a % b;
               end
               e_stall = DATA_W + 1;
               e_done  = DATA_W + 1;
            end
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
`ifdef MULDIV_MADD_EN
         3'd7: begin
            p = sa * sb;
            {m_hi, m_lo} = {m_hi, m_lo} + p;
            e_stall = MUL_LAT + 1;
            e_done  = MUL_LAT + 1;
         end
`endif
         default: ;
      endcase
   endtask

   // Present an op, hold it while stalled, then measure and compare.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      int st, dc, es, ed;
      bit dz, ez, fin;
      logic [31:0] dhi, dlo;
      model_op(op, a, b, es, ed, ez);
      @(negedge clk);
      start_i = 1'b1;
      md_op_i = op;
      reg1_i  = a;
      reg2_i  = b;
      st = 0; dc = -1; dz = 1'b0; fin = 1'b0;
      dhi = 'x; dlo = 'x;
      for (int c = 0; c < 200 && !fin; c++) begin
         #1;
         if (stallsignal) st++;
         if (done_o && dc < 0) begin
            dc  = c;
            dz  = div_by_zero_o;
            dhi = hi_o;
            dlo = lo_o;
         end
         if (!stallsignal) fin = 1'b1;
         @(negedge clk);
      end
      start_i = 1'b0;
      md_op_i = 3'd0;
      if (!fin) chk_eq({tag, " timeout"}, 64'd0, 64'd1);
      chk_eq({tag, " stall"}, 64'(st), 64'(es));
      chk_eq({tag, " done_cycle"}, 64'(dc), 64'(ed));
      chk_eq({tag, " dbz"}, 64'(dz), 64'(ez));
      if (ed >= 0) begin
         chk_eq({tag, " hi@done"}, 64'(dhi), 64'(m_hi));
         chk_eq({tag, " lo@done"}, 64'(dlo), 64'(m_lo));
      end
      #1;
      chk_eq({tag, " hi"}, 64'(hi_o), 64'(m_hi));
      chk_eq({tag, " lo"}, 64'(lo_o), 64'(m_lo));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      rst = 1'b1; start_i = 1'b0; md_op_i = 3'd0; reg1_i = '0; reg2_i = '0; flush_i = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("rst hi", 64'(hi_o), 64'd0);
      chk_eq("rst lo", 64'(lo_o), 64'd0);
      chk_eq("rst busy", 64'(busy_o), 64'd0);
      chk_eq("rst done", 64'(done_o), 64'd0);
      chk_eq("rst stall", 64'(stallsignal), 64'd0);
      chk_eq("rst dbz", 64'(div_by_zero_o), 64'd0);

      issue(3'd6, 32'h5, 32'h0, "mtlo");
      issue(3'd5, 32'h7, 32'h0, "mthi");
      chk_eq("mtlo const", 64'(lo_o), 64'h5);
      chk_eq("mthi const", 64'(hi_o), 64'h7);

      issue(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
      chk_eq("mult hi const", 64'(hi_o), 64'hFFFF_FFFF);
      chk_eq("mult lo const", 64'(lo_o), 64'hFFFF_FFFA);
      issue(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
      chk_eq("multu hi const", 64'(hi_o), 64'h2);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div -7/2");
      chk_eq("div lo const", 64'(lo_o), 64'hFFFF_FFFD);
      chk_eq("div hi const", 64'(hi_o), 64'hFFFF_FFFF);
      issue(3'd4, 32'd7, 32'd2, "divu 7/2");
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
      chk_eq("min/-1 lo const", 64'(lo_o), 64'h8000_0000);
      chk_eq("min/-1 hi const", 64'(hi_o), 64'h0);

      issue(3'd5, 32'h7, 32'h0, "mthi7");
      issue(3'd6, 32'h5, 32'h0, "mtlo5");
      issue(3'd3, 32'd9, 32'd0, "div 9/0");

      // Flush in DIV cycle 10: back to IDLE, no result, no done.
      @(negedge clk);
      start_i = 1'b1; md_op_i = 3'd3; reg1_i = 32'd100; reg2_i = 32'd7;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      #1;
      chk_eq("flush div stall before", 64'(stallsignal), 64'd1);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0; md_op_i = 3'd0;
      #1;
      chk_eq("flush stall", 64'(stallsignal), 64'd0);
      chk_eq("flush busy", 64'(busy_o), 64'd0);
      chk_eq("flush done", 64'(done_o), 64'd0);
      chk_eq("flush hi", 64'(hi_o), 64'(m_hi));
      chk_eq("flush lo", 64'(lo_o), 64'(m_lo));
      issue(3'd1, 32'd6, 32'hFFFF_FFFD, "mult after flush");

      // Flush in IDLE beats start, including mthi.
      @(negedge clk);
      start_i = 1'b1; md_op_i = 3'd5; reg1_i = 32'hDEAD_BEEF; flush_i = 1'b1;
      #1;
      chk_eq("idle flush mthi stall", 64'(stallsignal), 64'd0);
      @(negedge clk);
      md_op_i = 3'd1;
      #1;
      chk_eq("idle flush mult stall", 64'(stallsignal), 64'd0);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0; md_op_i = 3'd0;
      #1;
      chk_eq("idle flush hi", 64'(hi_o), 64'(m_hi));
      chk_eq("idle flush busy", 64'(busy_o), 64'd0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      start_i = 1'b1; md_op_i = 3'd1; reg1_i = 32'd5; reg2_i = 32'd5;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; start_i = 1'b0; md_op_i = 3'd0;
      m_hi = '0; m_lo = '0;
      #1;
      chk_eq("midrst busy", 64'(busy_o), 64'd0);
      chk_eq("midrst hi", 64'(hi_o), 64'd0);
      chk_eq("midrst lo", 64'(lo_o), 64'd0);

      // Accumulate (no-op when not built in).
      issue(3'd5, 32'h0, 32'h0, "mthi0");
      issue(3'd6, 32'h5, 32'h0, "mtlo5b");
      issue(3'd7, 32'd2, 32'd3, "madd 2x3");
      issue(3'd7, 32'hFFFF_FFFF, 32'd1, "madd -1x1");

      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick(), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting alongside the single-cycle execute stage. The execute stage hands it mult/div/move-to operands. It holds the pipeline through `stallsignal` while the operation iterates, and commits results to HI/LO. It generalises the execute stage's integer datapath to configurable width, adds multi-cycle sequencing and flush handling, and optionally adds accumulate ops.

## Interface
- `DATA_W`, 32: operand/HI/LO width; ≥ 8, even.
- `MUL_LAT`, 2: multiply busy cycles after accept; 1..4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (sampled on `clk`).
- `start_i`  in  1  op valid from execute stage; held until `stallsignal` low.
- `md_op_i`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (macro only).
- `reg1_i`  in  DATA_W  rs operand / dividend / move source.
- `reg2_i`  in  DATA_W  rt operand / divisor.
- `flush_i`  in  1  cancel in-flight op (branch/exception).
- `hi_o`, `lo_o`  out  DATA_W  registered HI/LO.
- `busy_o`  out  1  state is MUL or DIV.
- `done_o`  out  1  one-cycle pulse in DONE.
- `div_by_zero_o`  out  1  pulse in DONE when divisor was 0.
- `stallsignal`  out  1  combinational pipeline hold request.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset: IDLE, `hi_o`=`lo_o`=0, all other outputs 0, counter 0.
- IDLE + `start_i` + op 1/2/7 → MUL. Operands latched. Counter = MUL_LAT.
- IDLE + `start_i` + op 3/4 → DIV with counter = DATA_W. Divisor 0 → DONE directly, HI/LO untouched, `div_by_zero_o` flagged.
- IDLE + `start_i` + op 5/6: HI or LO ← `reg1_i` at that edge. No stall, stay IDLE.
- MUL: decrement each cycle. The edge where the counter reaches 0 writes {HI,LO} ← 2·DATA_W product and moves to DONE.
  - mult: signed × signed. multu: unsigned. madd: {HI,LO} + signed product, mod 2^(2·DATA_W).
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, MSB first. The final edge writes the result and moves to DONE.
  - LO = quotient, truncated toward zero. HI = remainder, sign of dividend.
  - div uses signed fixup; divu uses none.
  - MIN/−1: LO = MIN, HI = 0.
- DONE: `done_o`=1, `stallsignal`=0. `start_i` is ignored because the same instruction is still presented. Next state is IDLE.
- `flush_i` in MUL/DIV → IDLE next edge, HI/LO unchanged, no `done_o`.
- `flush_i` in IDLE beats `start_i`, including mthi/mtlo. Nothing is accepted.
- `flush_i` in DONE: results are already committed and HI/LO stay written. The state still goes to IDLE.
- `rst` overrides everything in every state.
- `stallsignal` = (IDLE ∧ `start_i` ∧ ¬`flush_i` ∧ op ∈ {1,2,3,4,7}) ∨ busy_o.
- op 0 and unknown op with `start_i`: no effect.

## Timing
- Cycle 0 is the accept cycle, with `stallsignal` high. Cycles 1..N are in MUL/DIV. Cycle N+1 is DONE.
  - N = MUL_LAT for mult; N = DATA_W for div.
  - `stallsignal` is high for exactly N+1 cycles.
- Div-by-zero: stall for cycle 0 only, then DONE in cycle 1.
- New HI/LO is visible on `hi_o`/`lo_o` from the DONE cycle.
- mthi/mtlo is visible the cycle after accept.
- A back-to-back op is accepted in the first IDLE cycle after DONE, never in DONE.
- No combinational path from `reg*_i` to outputs. Only `stallsignal` depends combinationally on `start_i`/`md_op_i`/`flush_i`.

## Configuration
- `MULDIV_MADD_EN` defined: op 7 (madd) accumulates as above and uses the MUL path.
- Undefined: op 7 is treated as op 0. No stall, no state change, and no accumulate adder is built.

## Test plan
- Reset → `hi_o`=`lo_o`=0, `busy_o`=`done_o`=`stallsignal`=0.
  - mtlo 0x5 then mthi 0x7 → LO=0x5, HI=0x7, never stalled.
- DATA_W=32, MUL_LAT=2:
  - mult 0xFFFFFFFE×3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall 3 cycles, `done_o` in cycle 3.
  - multu same operands → HI=0x2, LO=0xFFFFFFFA.
- div −7/2:
  - → LO=0xFFFFFFFD, HI=0xFFFFFFFF, stall 33 cycles.
  - divu 7/2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- div 9/0 with HI=0x7, LO=0x5 → `div_by_zero_o` pulse in cycle 1, HI/LO unchanged, stall 1 cycle.
- `flush_i` in DIV cycle 10 → IDLE next cycle, `stallsignal` low, no `done_o`, HI/LO unchanged.
  - New mult accepted in the following cycle.
- With `MULDIV_MADD_EN`, HI=0, LO=5:
  - madd 2×3 → LO=0xB, HI=0.
  - madd 0xFFFFFFFF×1 → LO=0xA, HI=0.
  - Without the macro, op 7 → no stall, HI/LO unchanged.
